// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if
//   Groups the memory-fetch handshake, the branch-resolution flush and the
//   decoder-facing head-of-queue signals of the instruction-fetch queue.
//   master : the fetch queue (drives the memory request and the queue head)
//   slave  : the surroundings (memory controller, branch unit, decoder)
//   Signals:
//     mem_req_o / mem_addr_o        fetch request and word-aligned address
//     mem_ack_i / mem_data_i        request done, fetched word valid this cycle
//     flush_i / flush_pc_i          redirect fetch and empty the queue
//     id_ready_i                    decoder accepts the head entry this cycle
//     valid_o / pc_o / inst_o /
//     jump_enable_o                 queue head presented to the decoder
interface if_fetch_queue_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        id_ready_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        jump_enable_o;

  modport master (
    output mem_req_o, mem_addr_o, valid_o, pc_o, inst_o, jump_enable_o,
    input  mem_ack_i, mem_data_i, flush_i, flush_pc_i, id_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, valid_o, pc_o, inst_o, jump_enable_o,
    output mem_ack_i, mem_data_i, flush_i, flush_pc_i, id_ready_i
  );
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   Instruction-fetch stage feeding the decoder. Issues one word fetch at a
//   time to the memory controller, statically predicts JAL and backward
//   branches to choose the next fetch address, and buffers fetched words in a
//   QUEUE_DEPTH-entry FIFO whose head is presented to the decoder.
//   Ports:
//     clk   clock
//     rst   asynchronous, active-high reset
//     rdy   global ready; 0 freezes every register
//     bus   if_fetch_queue_if.master (memory handshake, flush, queue head)
module if_fetch_queue #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  if_fetch_queue_if.master  bus
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    DROP
  } state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic [31:0]        mem_addr_q;
  logic               mem_req_q;

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic [31:0]        pc_mem   [QUEUE_DEPTH];
  logic [31:0]        inst_mem [QUEUE_DEPTH];
  logic               jump_mem [QUEUE_DEPTH];

  logic [31:0]        flush_target;
  logic [31:0]        j_imm;
  logic [31:0]        b_imm;
  logic [31:0]        pred_next_pc;
  logic               pred_jump;
  logic               not_empty;
  logic               not_full;
  logic               push;
  logic               pop;

  // Redirect targets are forced to a word boundary.
  assign flush_target = bus.flush_pc_i & 32'hFFFF_FFFC;

  assign not_empty = (count != '0);
  assign not_full  = (count < CNT_W'(QUEUE_DEPTH));

  // Only a non-flushed ack of a live request writes the queue; a frozen
  // pipeline (rdy=0) neither pushes nor pops.
  assign push = rdy && !bus.flush_i && (state == WAIT_MEM) && bus.mem_ack_i;
  assign pop  = rdy && !bus.flush_i && not_empty && bus.id_ready_i;

  // Static prediction on the returning word; the entry pc is fetch_pc,
  // which equals the outstanding request address while in WAIT_MEM.
  assign j_imm = {{11{bus.mem_data_i[31]}}, bus.mem_data_i[31], bus.mem_data_i[19:12],
                  bus.mem_data_i[20], bus.mem_data_i[30:21], 1'b0};
  assign b_imm = {{19{bus.mem_data_i[31]}}, bus.mem_data_i[31], bus.mem_data_i[7],
                  bus.mem_data_i[30:25], bus.mem_data_i[11:8], 1'b0};

  always_comb begin
    pred_jump    = 1'b0;
    pred_next_pc = fetch_pc + 32'd4;
    if (bus.mem_data_i[6:0] == OPC_JAL) begin
      pred_jump    = 1'b1;
      pred_next_pc = fetch_pc + j_imm;
    end else if ((bus.mem_data_i[6:0] == OPC_BRANCH) && bus.mem_data_i[31]) begin
      pred_jump    = 1'b1;
      pred_next_pc = fetch_pc + b_imm;
    end
  end

  // Fetch FSM. mem_addr_q only moves while no request is outstanding, so a
  // flush during WAIT_MEM updates fetch_pc but leaves the bus address alone
  // until the abandoned request is acknowledged in DROP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (bus.flush_i) begin
            fetch_pc   <= flush_target;
            mem_addr_q <= flush_target;
          end else if (not_full) begin
            state     <= WAIT_MEM;
            mem_req_q <= 1'b1;
          end
        end
        WAIT_MEM: begin
          if (bus.flush_i) begin
            fetch_pc <= flush_target;
            if (bus.mem_ack_i) begin
              state      <= IDLE;
              mem_req_q  <= 1'b0;
              mem_addr_q <= flush_target;
            end else begin
              state <= DROP;
            end
          end else if (bus.mem_ack_i) begin
            state      <= IDLE;
            mem_req_q  <= 1'b0;
            fetch_pc   <= pred_next_pc;
            mem_addr_q <= pred_next_pc;
          end
        end
        DROP: begin
          if (bus.flush_i) begin
            fetch_pc <= flush_target;
          end
          if (bus.mem_ack_i) begin
            state      <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= bus.flush_i ? flush_target : fetch_pc;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; flush clears everything regardless of any
  // simultaneous push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (bus.flush_i) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          tail <= tail + PTR_W'(1);
        end
        if (pop) begin
          head <= head + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Entry storage needs no reset: the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= fetch_pc;
      inst_mem[tail] <= bus.mem_data_i;
      jump_mem[tail] <= pred_jump;
    end
  end

  assign bus.mem_req_o     = mem_req_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.valid_o       = not_empty;
  assign bus.pc_o          = not_empty ? pc_mem[head]   : 32'h0;
  assign bus.inst_o        = not_empty ? inst_mem[head] : 32'h0;
  assign bus.jump_enable_o = not_empty ? jump_mem[head] : 1'b0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue
//   Directed scenarios followed by randomized traffic for if_fetch_queue,
//   compared every cycle against a transaction-level reference model built
//   on a queue of expected entries.
module tb_if_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        jump;
  } entry_t;

  logic clk;
  logic rst;
  logic rdy;

  if_fetch_queue_if bus();

  if_fetch_queue #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: expected queue contents plus the fetch engine's view.
  entry_t      mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_addr;
  bit          m_req;
  bit          m_drop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    mq.delete();
    m_fpc  = RPC;
    m_addr = RPC;
    m_req  = 1'b0;
    m_drop = 1'b0;
  endtask

  // Next-pc rule written directly from the ISA immediate formats.
  task automatic predict(input logic [31:0] pc, input logic [31:0] inst,
                         output logic [31:0] nxt, output logic jump);
    logic signed [20:0] jimm;
    logic signed [12:0] bimm;
    jimm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    bimm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    if (inst[6:0] == 7'b1101111) begin
      nxt  = pc + 32'(int'(jimm));
      jump = 1'b1;
    end else if (inst[6:0] == 7'b1100011 && inst[31]) begin
      nxt  = pc + 32'(int'(bimm));
      jump = 1'b1;
    end else begin
      nxt  = pc + 32'd4;
      jump = 1'b0;
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    entry_t h;
    h = '{32'h0, 32'h0, 1'b0};
    if (mq.size() != 0) h = mq[0];
    checkValue("mem_req",  32'(bus.mem_req_o),     32'(m_req));
    checkValue("mem_addr", bus.mem_addr_o,         m_addr);
    checkValue("valid",    32'(bus.valid_o),       32'(mq.size() != 0));
    checkValue("pc",       bus.pc_o,               h.pc);
    checkValue("inst",     bus.inst_o,             h.inst);
    checkValue("jump",     32'(bus.jump_enable_o), 32'(h.jump));
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic applyStimulus(input bit r, input bit ack, input logic [31:0] data,
                               input bit fl, input logic [31:0] fpc, input bit idr);
    logic [31:0] nxt;
    logic        j;
    int          sizeBefore;
    rdy            = r;
    bus.mem_ack_i  = ack;
    bus.mem_data_i = data;
    bus.flush_i    = fl;
    bus.flush_pc_i = fpc;
    bus.id_ready_i = idr;
    if (r) begin
      sizeBefore = mq.size();
      if (fl) begin
        mq.delete();
        m_fpc = {fpc[31:2], 2'b00};
        if (m_req) begin
          if (ack) begin
            m_req  = 1'b0;
            m_drop = 1'b0;
            m_addr = m_fpc;
          end else begin
            m_drop = 1'b1;
          end
        end else begin
          m_addr = m_fpc;
        end
      end else begin
        if (sizeBefore != 0 && idr) void'(mq.pop_front());
        if (m_req && ack) begin
          if (!m_drop) begin
            predict(m_addr, data, nxt, j);
            mq.push_back('{m_addr, data, j});
            m_fpc = nxt;
          end
          m_addr = m_fpc;
          m_req  = 1'b0;
          m_drop = 1'b0;
        end else if (!m_req && sizeBefore < DEPTH) begin
          m_req = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Wait (bounded) for a request, then acknowledge it with the given word.
  task automatic fetchOne(input logic [31:0] data, input bit idrWait, input bit idrAck);
    int n;
    n = 0;
    while (!m_req && n < 10) begin
      applyStimulus(1, 0, 32'h0, 0, 32'h0, idrWait);
      n++;
    end
    checks++;
    assert (m_req && bus.mem_req_o) else begin
      failures++;
      $error("[TB] FAIL fetch_timeout observed=%0d expected=1", bus.mem_req_o);
    end
    applyStimulus(1, 1, data, 0, 32'h0, idrAck);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] data;
    bit          ack;
    bit          fl;
    bit          rv;

    rst = 1'b1;
    rdy = 1'b1;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = 32'h0;
    bus.flush_i    = 1'b0;
    bus.flush_pc_i = 32'h0;
    bus.id_ready_i = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;

    $display("[TB] basic fetch");
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    checkValue("t1_req_raised", 32'(bus.mem_req_o), 32'd1);
    checkValue("t1_addr0",      bus.mem_addr_o,     32'h0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(1, 1, 32'h0000_0013, 0, 32'h0, 0);
    checkValue("t1_valid", 32'(bus.valid_o),       32'd1);
    checkValue("t1_pc",    bus.pc_o,               32'h0);
    checkValue("t1_inst",  bus.inst_o,             32'h13);
    checkValue("t1_jump",  32'(bus.jump_enable_o), 32'd0);
    checkValue("t1_req_bubble", 32'(bus.mem_req_o), 32'd0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
    checkValue("t1_next_req",  32'(bus.mem_req_o), 32'd1);
    checkValue("t1_next_addr", bus.mem_addr_o,     32'h4);

    $display("[TB] jal prediction");
    fetchOne(32'h0000_0013, 1, 1);
    fetchOne(32'h0000_0013, 1, 1);
    fetchOne(32'h0000_0013, 1, 1);
    fetchOne(32'h0080_00EF, 1, 0);
    checkValue("t2_pc",   bus.pc_o,               32'h10);
    checkValue("t2_jump", 32'(bus.jump_enable_o), 32'd1);
    checkValue("t2_addr", bus.mem_addr_o,         32'h18);

    $display("[TB] branch prediction");
    applyStimulus(1, 0, 32'h0, 1, 32'h20, 1);
    fetchOne(32'hFE00_0EE3, 1, 0);
    checkValue("t3_back_pc",   bus.pc_o,               32'h20);
    checkValue("t3_back_jump", 32'(bus.jump_enable_o), 32'd1);
    checkValue("t3_back_addr", bus.mem_addr_o,         32'h1C);
    applyStimulus(1, 0, 32'h0, 1, 32'h20, 1);
    fetchOne(32'h7E00_0EE3, 1, 0);
    checkValue("t3_fwd_jump", 32'(bus.jump_enable_o), 32'd0);
    checkValue("t3_fwd_addr", bus.mem_addr_o,         32'h24);

    $display("[TB] queue full");
    applyStimulus(1, 0, 32'h0, 1, 32'h0, 0);
    repeat (4) fetchOne(32'h0000_0013, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    checkValue("t4_full_no_req", 32'(bus.mem_req_o), 32'd0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
    checkValue("t4_pop_no_req", 32'(bus.mem_req_o), 32'd0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    checkValue("t4_req_after_pop", 32'(bus.mem_req_o), 32'd1);
    checkValue("t4_addr",          bus.mem_addr_o,     32'h10);

    $display("[TB] flush during request");
    applyStimulus(1, 0, 32'h0, 1, 32'h0, 0);
    applyStimulus(1, 1, 32'h1234_5678, 0, 32'h0, 0);
    fetchOne(32'h0000_0013, 0, 0);
    fetchOne(32'h0000_0013, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    checkValue("t5_wait_addr", bus.mem_addr_o, 32'h8);
    applyStimulus(1, 0, 32'h0, 1, 32'h103, 0);
    checkValue("t5_valid_clear", 32'(bus.valid_o), 32'd0);
    checkValue("t5_addr_hold",   bus.mem_addr_o,   32'h8);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    checkValue("t5_addr_hold2",  bus.mem_addr_o,   32'h8);
    applyStimulus(1, 1, 32'hDEAD_BEEF, 0, 32'h0, 0);
    checkValue("t5_dropped", 32'(bus.valid_o), 32'd0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    checkValue("t5_redirect_addr", bus.mem_addr_o, 32'h100);

    $display("[TB] rdy freeze");
    applyStimulus(1, 1, 32'h0000_0013, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
    applyStimulus(0, 1, 32'h0000_00EF, 0, 32'h0, 1);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
    checkValue("t6_valid_hold", 32'(bus.valid_o),   32'd1);
    checkValue("t6_pc_hold",    bus.pc_o,           32'h100);
    checkValue("t6_addr_hold",  bus.mem_addr_o,     32'h104);
    checkValue("t6_req_hold",   32'(bus.mem_req_o), 32'd1);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
    checkValue("t6_resume_pop", 32'(bus.valid_o), 32'd0);

    $display("[TB] async reset mid-request");
    rst = 1'b1;
    #1;
    modelReset();
    checkValue("rst_async_req", 32'(bus.mem_req_o), 32'd0);
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      r = $urandom();
      case ($urandom_range(0, 3))
        0:       data = {r[31:7], 7'b1101111};
        1:       data = {r[31:7], 7'b1100011};
        2:       data = {r[31:7], 7'b1100111};
        default: data = r;
      endcase
      rv  = ($urandom_range(0, 9) != 0);
      ack = m_req && ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      applyStimulus(rv, ack, data, fl, $urandom(), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
